// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump squash of
// FLUSH_CYCLES cycles and MD_CYCLES-cycle mul/div occupancy stalls.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MD_CYCLES    = 4,
    parameter int CNT_W        = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic       BranchTaken,
    input  logic       Jump,
    input  logic       MD_Start,
    output logic       PC_Stall,
    output logic       IF_Stall,
    output logic       Flash,
    output logic       EX_Bubble,
    output logic       MD_Busy,
    output logic [1:0] state
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_MDWAIT = 2'd2;

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] MD_LOAD    = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_lu;
    logic             w_redirect;

    assign w_lu = EX_MemRead && (EX_rt != 5'd0) &&
                  ((EX_rt == ID_rs) || (EX_rt == ID_rt));
    assign w_redirect = BranchTaken || Jump;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Single-cycle sequences never leave RUN; the counter only runs in FLUSH/MDWAIT.
    always_comb begin
        w_next_state = S_RUN;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_redirect) begin
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state = S_FLUSH;
                        w_next_cnt   = FLUSH_LOAD;
                    end
                end else if (MD_Start) begin
                    if (MD_CYCLES > 1) begin
                        w_next_state = S_MDWAIT;
                        w_next_cnt   = MD_LOAD;
                    end
                end
            end
            S_FLUSH, S_MDWAIT: begin
                w_next_cnt   = r_cnt - CNT_ONE;
                w_next_state = (r_cnt == CNT_ONE) ? S_RUN : r_state;
            end
            default: begin
                w_next_state = S_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        PC_Stall  = 1'b0;
        IF_Stall  = 1'b0;
        Flash     = 1'b0;
        EX_Bubble = 1'b0;
        MD_Busy   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_redirect) begin
                    Flash = 1'b1;
                end else if (MD_Start) begin
                    PC_Stall  = 1'b1;
                    IF_Stall  = 1'b1;
                    EX_Bubble = 1'b1;
                    MD_Busy   = 1'b1;
                end else if (w_lu) begin
                    PC_Stall  = 1'b1;
                    IF_Stall  = 1'b1;
                    EX_Bubble = 1'b1;
                end
            end
            S_FLUSH: begin
                Flash = 1'b1;
            end
            S_MDWAIT: begin
                PC_Stall  = 1'b1;
                IF_Stall  = 1'b1;
                EX_Bubble = 1'b1;
                MD_Busy   = 1'b1;
            end
            default: begin
                Flash = 1'b0;
            end
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with FLUSH_CYCLES=2, MD_CYCLES=4,
// compared against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int MD_CYCLES    = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] ID_rs, ID_rt, EX_rt;
    logic       EX_MemRead, BranchTaken, Jump, MD_Start;
    logic       PC_Stall, IF_Stall, Flash, EX_Bubble, MD_Busy;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    // Model: number of cycles still owed to an in-progress squash / stall.
    int         flush_rem = 0;
    int         md_rem    = 0;
    logic [6:0] exp_vec;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MD_CYCLES   (MD_CYCLES),
        .CNT_W       (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .EX_MemRead (EX_MemRead),
        .EX_rt      (EX_rt),
        .BranchTaken(BranchTaken),
        .Jump       (Jump),
        .MD_Start   (MD_Start),
        .PC_Stall   (PC_Stall),
        .IF_Stall   (IF_Stall),
        .Flash      (Flash),
        .EX_Bubble  (EX_Bubble),
        .MD_Busy    (MD_Busy),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    // Packed as {PC_Stall, IF_Stall, Flash, EX_Bubble, MD_Busy, state}.
    function automatic logic [6:0] obs();
        return {PC_Stall, IF_Stall, Flash, EX_Bubble, MD_Busy, state};
    endfunction

    task automatic model_eval();
        bit lu;
        lu = EX_MemRead && (EX_rt != 0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));
        if (flush_rem > 0)              exp_vec = {5'b00100, 2'd1};
        else if (md_rem > 0)            exp_vec = {5'b11011, 2'd2};
        else if (BranchTaken || Jump)   exp_vec = {5'b00100, 2'd0};
        else if (MD_Start)              exp_vec = {5'b11011, 2'd0};
        else if (lu)                    exp_vec = {5'b11010, 2'd0};
        else                            exp_vec = {5'b00000, 2'd0};
    endtask

    task automatic model_adv();
        if (RST) begin
            flush_rem = 0;
            md_rem    = 0;
        end else if (flush_rem > 0)     flush_rem--;
        else if (md_rem > 0)            md_rem--;
        else if (BranchTaken || Jump)   flush_rem = FLUSH_CYCLES - 1;
        else if (MD_Start)              md_rem = MD_CYCLES - 1;
    endtask

    task automatic set_in(input bit rst, input bit br, input bit jmp, input bit md,
                          input bit mr, input logic [4:0] ert,
                          input logic [4:0] rs, input logic [4:0] rt);
        RST = rst; BranchTaken = br; Jump = jmp; MD_Start = md;
        EX_MemRead = mr; EX_rt = ert; ID_rs = rs; ID_rt = rt;
        #1;
    endtask

    task automatic advance();
        @(posedge CLK);
        model_adv();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        advance();
        // Second reset cycle: state known to be RUN, Flash follows BranchTaken.
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        model_eval();
        checks++;
        if (obs() !== exp_vec) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", obs(), exp_vec);
        end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_eval();
        checks++;
        if (obs() !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", obs(), 7'b0);
        end
        advance();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_in(0, 0, 0, 0, 1, 5, 5, 0);
                1: set_in(0, 0, 0, 0, 0, 0, 0, 0);
                2: set_in(0, 0, 0, 0, 1, 0, 0, 0);
                3: set_in(0, 0, 0, 0, 1, 9, 3, 9);
                default: set_in(0, 0, 0, 0, 1, 9, 3, 4);
            endcase
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_branch();
        // Branch, then MD_Start + LU while squashing, then a jump, then idle.
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_in(0, 1, 0, 0, 0, 0, 0, 0);
                1: set_in(0, 0, 0, 1, 1, 7, 7, 7);
                2: set_in(0, 0, 0, 0, 0, 0, 0, 0);
                3: set_in(0, 0, 1, 0, 0, 0, 0, 0);
                4: set_in(0, 1, 0, 0, 0, 0, 0, 0);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_muldiv();
        // MD_Start, then LU and branch requests during MDWAIT, then idle.
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_in(0, 0, 0, 1, 0, 0, 0, 0);
                1, 2: set_in(0, 0, 0, 0, 1, 3, 3, 0);
                3: set_in(0, 1, 0, 1, 1, 3, 0, 3);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL muldiv[%0d] got=%b exp=%b", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_in(0, 1, 0, 1, 1, 6, 6, 6);
                1: set_in(0, 0, 0, 0, 0, 0, 0, 0);
                default: set_in(0, 0, 0, 1, 1, 6, 6, 6);
            endcase
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL priority[%0d] got=%b exp=%b", i, obs(), exp_vec);
            end
            advance();
        end
        // Let the trailing mul/div drain before the next scenario.
        for (int i = 0; i < MD_CYCLES; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_in(0, 0, 0, 1, 0, 0, 0, 0);
                1: set_in(0, 0, 0, 0, 0, 0, 0, 0);
                2: set_in(1, 0, 0, 0, 0, 0, 0, 0);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL reset_mid[%0d] got=%b exp=%b", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 60) == 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 11) == 0,
                   $urandom_range(0, 6) == 0,
                   $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)));
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL random[%0d] got=%b exp=%b", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
